// File: rtl/bht_pkg.sv
// ============================================================================
// Module      : bht_pkg
// Description : Shared sizes, token encodings and sweep-state type for the
//               branch history table.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bht_pkg;

    localparam int BHT_DEPTH = 1024;
    localparam int BHT_IDX_W = 10;
    localparam int BHT_GRP   = 16;
    localparam int BHT_NGRP  = 64;
    localparam int BHT_GRP_W = 6;
    localparam int BHT_ENT_W = 34;

    typedef enum logic [1:0] {
        TOK_SNT = 2'b00,
        TOK_WNT = 2'b01,
        TOK_WT  = 2'b10,
        TOK_ST  = 2'b11
    } bht_token_e;

    localparam logic [1:0] BHT_RST_TOKEN = TOK_WNT;

    typedef enum logic [0:0] {
        SW_IDLE  = 1'b0,
        SW_SWEEP = 1'b1
    } sweep_state_e;

endpackage

`default_nettype wire

// File: rtl/bht_inv_sweeper.sv
// ============================================================================
// Module      : bht_inv_sweeper
// Description : IDLE/SWEEP controller that walks the 64 valid-bit groups, one
//               group per cycle, after an invalidate request.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bht_inv_sweeper
    import bht_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inv_req_i,
    output logic                 busy_o,
    output logic [BHT_GRP_W-1:0] grp_o,
    output logic                 clr_en_o
);

    sweep_state_e         state_q;
    logic [BHT_GRP_W-1:0] grp_q;
    logic                 busy_q;

    // Requests arriving mid-sweep are dropped: only IDLE looks at inv_req_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SW_IDLE;
            grp_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                SW_IDLE: begin
                    if (inv_req_i) begin
                        state_q <= SW_SWEEP;
                        busy_q  <= 1'b1;
                        grp_q   <= '0;
                    end
                end
                SW_SWEEP: begin
                    if (grp_q == BHT_GRP_W'(BHT_NGRP - 1)) begin
                        state_q <= SW_IDLE;
                        busy_q  <= 1'b0;
                        grp_q   <= '0;
                    end else begin
                        grp_q <= grp_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= SW_IDLE;
                    busy_q  <= 1'b0;
                    grp_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign grp_o    = grp_q;
    assign clr_en_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/bht_unit.sv
// ============================================================================
// Module      : bht_unit
// Description : 1024-entry untagged branch history table with zero-cycle
//               lookup and a 64-cycle background invalidate sweep.
//               Optional macro BHT_WR_BYPASS_EN forwards a same-cycle write
//               to the lookup outputs.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bht_unit
    import bht_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          fetch_pc,
    output logic [1:0]           pred_token,
    output logic                 pred_taken,
    output logic [31:0]          pred_pc,
    input  logic                 bht_we,
    input  logic [BHT_IDX_W-1:0] bht_write_addr,
    input  logic [BHT_ENT_W-1:0] bht_din,
    input  logic                 inv_req,
    output logic                 inv_busy
);

    logic                 w_sw_busy;
    logic [BHT_GRP_W-1:0] w_sw_grp;
    logic                 w_sw_clr;

    bht_inv_sweeper u_sweeper (
        .clk       (clk),
        .rst       (rst),
        .inv_req_i (inv_req),
        .busy_o    (w_sw_busy),
        .grp_o     (w_sw_grp),
        .clr_en_o  (w_sw_clr)
    );

    logic [BHT_DEPTH-1:0] valid_q;
    logic [BHT_DEPTH-1:0] valid_d;
    logic [BHT_ENT_W-1:0] mem_q [BHT_DEPTH];

    // Clear first, then write, so a write into the group being swept survives.
    always_comb begin
        valid_d = valid_q;
        if (w_sw_clr) begin
            valid_d[{w_sw_grp, 4'b0000} +: BHT_GRP] = '0;
        end
        if (bht_we) begin
            valid_d[bht_write_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is never reset; the valid bit alone decides whether it is used.
    always_ff @(posedge clk) begin
        if (bht_we) begin
            mem_q[bht_write_addr] <= bht_din;
        end
    end

    logic [BHT_IDX_W-1:0] w_idx;
    logic [BHT_ENT_W-1:0] w_rd_entry;
    logic                 w_rd_valid;
    logic                 w_use;
    logic [31:0]          w_pc_inc;

    assign w_idx    = fetch_pc[BHT_IDX_W+1:2];
    assign w_pc_inc = fetch_pc + 32'd4;

    always_comb begin
        w_rd_entry = mem_q[w_idx];
        w_rd_valid = valid_q[w_idx];
`ifdef BHT_WR_BYPASS_EN
        if (bht_we && (bht_write_addr == w_idx)) begin
            w_rd_entry = bht_din;
            w_rd_valid = 1'b1;
        end
`endif
    end

    assign w_use      = w_rd_valid && !w_sw_busy;
    assign pred_token = w_use ? w_rd_entry[33:32] : BHT_RST_TOKEN;
    assign pred_taken = w_use && w_rd_entry[33];
    assign pred_pc    = pred_taken ? w_rd_entry[31:0] : w_pc_inc;
    assign inv_busy   = w_sw_busy;

endmodule

`default_nettype wire

// File: tb/tb_bht_unit.sv
// ============================================================================
// Module      : tb_bht_unit
// Description : Scoreboard bench for bht_unit: directed scenarios plus random
//               traffic against a table-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bht_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic [1:0]  pred_token;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        bht_we = 1'b0;
    logic [9:0]  bht_write_addr = '0;
    logic [33:0] bht_din = '0;
    logic        inv_req = 1'b0;
    logic        inv_busy;

    bht_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .pred_token     (pred_token),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .bht_we         (bht_we),
        .bht_write_addr (bht_write_addr),
        .bht_din        (bht_din),
        .inv_req        (inv_req),
        .inv_busy       (inv_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fpc;
        logic [1:0]  tok;
        logic        taken;
        logic [31:0] pc;
        logic        busy;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference table: plain arrays plus a "groups left to clear" view of the sweep.
    bit          m_valid [1024];
    logic [1:0]  m_tok   [1024];
    logic [31:0] m_tgt   [1024];
    int          m_sweep_left = 0;

    function automatic exp_t predict(input logic [31:0] fpc, input logic we,
                                     input logic [9:0] a, input logic [33:0] d);
        exp_t e;
        int   idx;
        bit   v;
        logic [1:0]  t;
        logic [31:0] g;
        idx = int'(fpc[11:2]);
        v = m_valid[idx];
        t = m_tok[idx];
        g = m_tgt[idx];
`ifdef BHT_WR_BYPASS_EN
        if (we && int'(a) == idx) begin
            v = 1'b1;
            t = d[33:32];
            g = d[31:0];
        end
`else
        if (we && a == 10'h3FF && d == '1) v = v;
`endif
        e.fpc  = fpc;
        e.busy = rst && (m_sweep_left > 0);
        if (!rst || e.busy || !v) begin
            e.tok   = 2'b01;
            e.taken = 1'b0;
            e.pc    = fpc + 32'd4;
        end else begin
            e.tok   = t;
            e.taken = t[1];
            e.pc    = t[1] ? g : fpc + 32'd4;
        end
        return e;
    endfunction

    task automatic model_edge();
        int grp;
        if (!rst) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_sweep_left = 0;
            return;
        end
        if (m_sweep_left > 0) begin
            grp = 64 - m_sweep_left;
            for (int j = grp * 16; j < grp * 16 + 16; j++) m_valid[j] = 1'b0;
            m_sweep_left--;
        end else if (inv_req) begin
            m_sweep_left = 64;
        end
        if (bht_we) begin
            m_valid[bht_write_addr] = 1'b1;
            m_tok[bht_write_addr]   = bht_din[33:32];
            m_tgt[bht_write_addr]   = bht_din[31:0];
        end
    endtask

    // Called just after a rising edge: apply inputs, log expectation, advance.
    task automatic drive(input logic [31:0] fpc, input logic we, input logic [9:0] a,
                         input logic [33:0] d, input logic inv);
        fetch_pc       = fpc;
        bht_we         = we;
        bht_write_addr = a;
        bht_din        = d;
        inv_req        = inv;
        sbq.push_back(predict(fpc, we, a, d));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic look(input logic [31:0] fpc);
        drive(fpc, 1'b0, 10'h0, 34'h0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] fpc,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s fetch_pc=%h got=%h want=%h t=%0t", nm, fpc, act, exp, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("pred_token", e.fpc, 32'(pred_token), 32'(e.tok));
            chk("pred_taken", e.fpc, 32'(pred_taken), 32'(e.taken));
            chk("pred_pc",    e.fpc, pred_pc,         e.pc);
            chk("inv_busy",   e.fpc, 32'(inv_busy),   32'(e.busy));
        end
    end

    localparam logic [9:0] ADDR_SET [8] = '{10'h010, 10'h011, 10'h000, 10'h3FF,
                                             10'h050, 10'h020, 10'h3F0, 10'h123};

    initial begin
        logic        we;
        logic [9:0]  a;
        logic [31:0] r;
        logic [9:0]  ri;

        @(posedge clk); #1;
        look(32'h0000_0040);
        look(32'h0000_0040);
        rst = 1'b1;
        look(32'h0000_0040);

        // Same-cycle write/lookup, then visibility on the following cycle.
        drive(32'h0000_0040, 1'b1, 10'h010, {2'b11, 32'h0000_0100}, 1'b0);
        look(32'h0000_0040);
        drive(32'h0000_0044, 1'b1, 10'h011, {2'b01, 32'h0000_0200}, 1'b0);
        look(32'h0000_0044);
        look(32'hFFFF_FFFC);

        drive(32'h0, 1'b1, 10'h000, {2'b11, 32'hAAAA_0000}, 1'b0);
        drive(32'h0, 1'b1, 10'h3FF, {2'b10, 32'hBBBB_0000}, 1'b0);
        look(32'h0000_0000);
        look(32'h0000_0FFC);

        // Sweep with a re-request, writes ahead of / behind / into the cleared group.
        drive(32'h0, 1'b0, 10'h0, 34'h0, 1'b1);
        for (int k = 0; k < 64; k++) begin
            we = 1'b0;
            a  = 10'h0;
            if (k == 3)  begin we = 1'b1; a = 10'h020; end
            if (k == 5)  begin we = 1'b1; a = 10'h050; end
            if (k == 20) begin we = 1'b1; a = 10'h3F0; end
            drive((k % 2 == 0) ? 32'h0000_0000 : 32'h0000_0FFC, we, a,
                  {2'b11, 32'h0000_1000 + 32'(k)}, (k == 10));
        end
        look(32'h0000_0000);
        look(32'h0000_0FFC);
        look(32'h0000_0140);
        look(32'h0000_0080);
        look(32'h0000_0FC0);
        look(32'h0000_0040);

        // Reset in the middle of a sweep aborts it and leaves the table invalid.
        drive(32'h0000_0140, 1'b0, 10'h0, 34'h0, 1'b1);
        look(32'h0000_0140);
        look(32'h0000_0140);
        rst = 1'b0;
        look(32'h0000_0140);
        rst = 1'b1;
        look(32'h0000_0140);
        look(32'h0000_0080);

        for (int n = 0; n < 500; n++) begin
            r  = $urandom;
            ri = ADDR_SET[$urandom_range(0, 7)];
            we = ($urandom_range(0, 2) == 0);
            a  = ADDR_SET[$urandom_range(0, 7)];
            drive({r[31:12], ri, 2'b00}, we, a, {2'($urandom), 32'($urandom)},
                  ($urandom_range(0, 80) == 0));
        end
        for (int n = 0; n < 70; n++) look({20'h0, ADDR_SET[n % 8], 2'b00});

        @(negedge clk); #1;
        n_checks++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/bht_unit.md
BHT_UNIT -- requirements
Module: bht_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-003 SHALL have ports: fetch_pc  in  32  fetch-stage PC to predict.
REQ-004 SHALL have ports: pred_token  out  2  2-bit counter for fetch_pc, carried down the pipe as bht_token.
REQ-005 SHALL have ports: pred_taken  out  1  predict taken (valid entry and token[1]).
REQ-006 SHALL have ports: pred_pc  out  32  next fetch PC (stored target if pred_taken, else fetch_pc+4).
REQ-007 SHALL have ports: bht_we  in  1  update strobe from memory stage.
REQ-008 SHALL have ports: bht_write_addr  in  10  entry index (PC[11:2] of resolved branch).
REQ-009 SHALL have ports: bht_din  in  34  {next_token[33:32], target[31:0]}.
REQ-010 SHALL have ports: inv_req  in  1  single-cycle pulse, invalidate whole table.
REQ-011 SHALL have ports: inv_busy  out  1  invalidate sweep in progress.

Function
REQ-012 SHALL hold 1024 entries of {valid, token[1:0], target[31:0]}, indexed by PC[11:2]; no tag.
REQ-013 SHALL produce pred_token/pred_taken/pred_pc combinationally from fetch_pc (zero-cycle lookup).
REQ-014 SHALL return token 2'b01, pred_taken=0, pred_pc=fetch_pc+4 (32-bit wrap) for an invalid entry.
REQ-015 SHALL, on rising clk with bht_we=1, write bht_din into entry bht_write_addr and set its valid bit; visible to lookups from the next cycle.
REQ-016 SHALL implement FSM IDLE/SWEEP: IDLE->SWEEP on inv_req=1; SWEEP clears valid bits of 16 entries per cycle (group index 0..63); SWEEP->IDLE after group 63 (exactly 64 cycles).
REQ-017 SHALL drive inv_busy=1 in every SWEEP cycle, 0 in IDLE.
REQ-018 SHALL ignore inv_req while in SWEEP (no restart, no extension).
REQ-019 SHALL force pred_taken=0, pred_token=2'b01, pred_pc=fetch_pc+4 while inv_busy=1, regardless of entry state.
REQ-020 SHALL, when bht_we targets the group being cleared in the same cycle, apply clear then write (written entry ends valid).
REQ-021 SHALL accept bht_we to already-swept or not-yet-swept groups normally; not-yet-swept entries are cleared when their group is reached.
REQ-022 SHALL not modify token or target fields on invalidate; only valid bits clear.

Reset
REQ-023 SHALL, while rst=0, clear all 1024 valid bits, FSM=IDLE, group counter=0, inv_busy=0.
REQ-024 SHALL leave token/target storage unreset (valid gating makes contents don't-care).
REQ-025 SHALL abort an active sweep on reset; post-reset table is fully invalid.
REQ-026 SHALL give, during and immediately after reset, pred_taken=0, pred_token=2'b01, pred_pc=fetch_pc+4.

Configuration
REQ-027 SHALL, with BHT_WR_BYPASS_EN defined, forward bht_din to lookup outputs when bht_we=1, bht_write_addr==fetch_pc[11:2] and inv_busy=0 (same-cycle write-to-read bypass).
REQ-028 SHALL, without BHT_WR_BYPASS_EN, return pre-write array contents for a same-cycle same-index lookup.

Structure
REQ-029 SHALL place BHT_DEPTH=1024, BHT_IDX_W=10, BHT_GRP=16, BHT_NGRP=64, token encodings (SNT=00, WNT=01, WT=10, ST=11) and reset token constant in shared package bht_pkg.
REQ-030 SHALL implement the IDLE/SWEEP FSM and group counter in sub-module bht_inv_sweeper (outputs: busy, group index, clear enable).

Verification
REQ-031 Reset, fetch_pc=0x0000_0040 -> pred_taken=0, pred_token=01, pred_pc=0x0000_0044.
REQ-032 bht_we=1, addr=0x010, din={2'b11,0x0000_0100}; next cycle fetch_pc=0x0000_0040 -> pred_taken=1, pred_token=11, pred_pc=0x0000_0100.
REQ-033 Write token 2'b01 target 0x200 at addr 0x011; fetch_pc=0x44 -> pred_taken=0, pred_token=01, pred_pc=0x48.
REQ-034 Fill addr 0x000 and 0x3FF taken, pulse inv_req -> inv_busy high exactly 64 cycles, predictions forced not-taken throughout, both entries invalid afterwards; second inv_req at cycle 10 has no effect.
REQ-035 During sweep at group 5, bht_we addr 0x050 (group 5) -> entry valid after sweep; write addr 0x020 (group 2, already swept) -> valid after sweep; write addr 0x3F0 before group 63 reached -> invalid after sweep.
REQ-036 With BHT_WR_BYPASS_EN: same-cycle bht_we addr 0x010 din {11,0x100} and fetch_pc=0x40 -> pred_pc=0x100 that cycle; without macro -> pred_pc=0x44 that cycle, 0x100 next.
